// File: rtl/spi_shift.sv
// -----------------------------------------------------------------------------
// spi_shift -- parallel-load / serial-shift data engine of the SPI master.
//
// Holds one transfer character. While idle the register file can write it
// byte by byte. During a transfer the character is shifted out on mosi and
// miso is sampled back into the same register, bit for bit in place. Bit
// timing comes from one-cycle sclk edge strobes made by the clock generator.
//
// Ports:
//   wb_clk, wb_reset   clock, synchronous active-low reset
//   go                 start request (ignored while a transfer runs)
//   len                character length, 0 selects SPI_MAX_CHAR bits
//   lsb                1 = LSB first, 0 = MSB first
//   rx_negedge         sample miso on the falling (1) or rising (0) strobe
//   tx_negedge         drive mosi on the falling (1) or rising (0) strobe
//   latch, byte_sel    word / byte write enables for p_in (idle only)
//   p_in               parallel write data
//   sclk               current serial clock level
//   cpol_0, cpol_1     rising / falling sclk edge strobes
//   miso               serial input
//   p_out              data register contents
//   mosi               registered serial output
//   tip                transfer in progress
//   last               bit counter is zero
//
// SPI_MAX_CHAR must not exceed 128 (four 32-bit latch words).
// -----------------------------------------------------------------------------
module spi_shift #(
   parameter int SPI_MAX_CHAR      = 32,
   parameter int SPI_CHAR_LEN_BITS = 5
) (
   input  logic                         wb_clk,
   input  logic                         wb_reset,
   input  logic                         go,
   input  logic [SPI_CHAR_LEN_BITS-1:0] len,
   input  logic                         lsb,
   input  logic                         rx_negedge,
   input  logic                         tx_negedge,
   input  logic [3:0]                   latch,
   input  logic [3:0]                   byte_sel,
   input  logic [31:0]                  p_in,
   input  logic                         sclk,
   input  logic                         cpol_0,
   input  logic                         cpol_1,
   input  logic                         miso,
   output logic [SPI_MAX_CHAR-1:0]      p_out,
   output logic                         mosi,
   output logic                         tip,
   output logic                         last
);

   // Counter / position arithmetic is one bit wider than len so that the
   // full length SPI_MAX_CHAR is representable.
   localparam int                CW      = SPI_CHAR_LEN_BITS + 1;
   localparam logic [CW-1:0]     MAX_LEN = CW'(SPI_MAX_CHAR);
   localparam logic [CW-1:0]     ONE     = CW'(1);

   logic [SPI_MAX_CHAR-1:0]      data_q, data_d;
   logic [CW-1:0]                cnt_q,  cnt_d;
   logic                         tip_q,  tip_d;
   logic                         mosi_q, mosi_d;

   logic [CW-1:0]                char_len;
   logic [CW-1:0]                tx_pos, rx_pos;
   logic [SPI_CHAR_LEN_BITS-1:0] tx_idx, rx_idx;
   logic                         tx_clk, rx_clk;

   // Bit-position decode.
   always_comb begin
      char_len = (len == '0) ? MAX_LEN : {1'b0, len};
      last     = (cnt_q == '0);

      tx_clk = (tx_negedge ? cpol_1 : cpol_0) & ~last;
      // With sclk high the final trailing-edge sample is still allowed after
      // the counter has reached zero.
      rx_clk = (rx_negedge ? cpol_1 : cpol_0) & (~last | sclk);

      tx_pos = lsb ? (char_len - cnt_q) : (cnt_q - ONE);
      // A falling-edge sample happens after cnt already decremented on the
      // preceding rising strobe, hence the one-position correction.
      if (lsb) begin
         rx_pos = char_len - (rx_negedge ? (cnt_q + ONE) : cnt_q);
      end else begin
         rx_pos = rx_negedge ? cnt_q : (cnt_q - ONE);
      end

      tx_idx = tx_pos[SPI_CHAR_LEN_BITS-1:0];
      rx_idx = rx_pos[SPI_CHAR_LEN_BITS-1:0];
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every variable gets a hold default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      data_d = data_q;
      cnt_d  = cnt_q;
      tip_d  = tip_q;
      mosi_d = mosi_q;

      if (!tip_q) begin
         cnt_d = char_len;
         tip_d = go;
         // Byte-enabled parallel load; data bit k sits in word k/32, byte
         // (k%32)/8 of that word.
         for (int k = 0; k < SPI_MAX_CHAR; k++) begin
            if (latch[k / 32] && byte_sel[(k % 32) / 8]) begin
               data_d[k] = p_in[k % 32];
            end
         end
      end else begin
         // On the terminating strobe cnt wraps for one cycle; the idle
         // reload on the next cycle restores it.
         if (cpol_0) begin
            cnt_d = cnt_q - ONE;
         end
         if (last && cpol_0) begin
            tip_d = 1'b0;
         end
         if (rx_clk) begin
            data_d[rx_idx] = miso;
         end
      end

      // While idle mosi continuously previews the first bit to be sent.
      if (tx_clk || !tip_q) begin
         mosi_d = data_q[tx_idx];
      end
   end

   always_ff @(posedge wb_clk) begin
      // NOTE: state flops use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!wb_reset) begin
         data_q <= '0;
         cnt_q  <= '0;
         tip_q  <= 1'b0;
         mosi_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         tip_q  <= tip_d;
         mosi_q <= mosi_d;
      end
   end

   assign p_out = data_q;
   assign mosi  = mosi_q;
   assign tip   = tip_q;

endmodule

// File: tb/tb_spi_shift.sv
// -----------------------------------------------------------------------------
// tb_spi_shift -- directed self-checking bench for spi_shift.
//
// Strobes are driven by the bench: two quiet cycles, a cpol_0 cycle (sclk low,
// rising afterwards), two quiet cycles, a cpol_1 cycle (sclk high, falling
// afterwards). Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_spi_shift;

   logic        wb_clk = 1'b0;
   logic        wb_reset;
   logic        go;
   logic [4:0]  len;
   logic        lsb;
   logic        rx_negedge;
   logic        tx_negedge;
   logic [3:0]  latch;
   logic [3:0]  byte_sel;
   logic [31:0] p_in;
   logic        sclk;
   logic        cpol_0;
   logic        cpol_1;
   logic        miso;
   logic [31:0] p_out;
   logic        mosi;
   logic        tip;
   logic        last;

   logic        loop_en;
   logic        miso_drv;

   int          n_cmp = 0;
   int          n_err = 0;

   logic [31:0] bits;
   int          strobes;
   logic        aborted;

   assign miso = loop_en ? mosi : miso_drv;

   always #5 wb_clk = ~wb_clk;

   spi_shift #(
      .SPI_MAX_CHAR      (32),
      .SPI_CHAR_LEN_BITS (5)
   ) dut (
      .wb_clk     (wb_clk),
      .wb_reset   (wb_reset),
      .go         (go),
      .len        (len),
      .lsb        (lsb),
      .rx_negedge (rx_negedge),
      .tx_negedge (tx_negedge),
      .latch      (latch),
      .byte_sel   (byte_sel),
      .p_in       (p_in),
      .sclk       (sclk),
      .cpol_0     (cpol_0),
      .cpol_1     (cpol_1),
      .miso       (miso),
      .p_out      (p_out),
      .mosi       (mosi),
      .tip        (tip),
      .last       (last)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic load(input logic [3:0] l, input logic [3:0] bs, input logic [31:0] d);
      latch    = l;
      byte_sel = bs;
      p_in     = d;
      tick();
      latch    = 4'h0;
      byte_sel = 4'h0;
      p_in     = 32'h0;
   endtask

   task automatic strobe0();
      sclk   = 1'b0;
      cpol_0 = 1'b1;
      tick();
      cpol_0 = 1'b0;
      sclk   = 1'b1;
   endtask

   task automatic strobe1();
      cpol_1 = 1'b1;
      tick();
      cpol_1 = 1'b0;
      sclk   = 1'b0;
   endtask

   // Runs one transfer. bits collects mosi after each shifting cpol_0 strobe
   // (first bit ends up most significant); strobes counts cpol_0 strobes seen
   // with tip high, including the one that ends the transfer.
   task automatic run_xfer(input int inject_at, input int abort_at,
                           output logic [31:0] b, output int n0, output logic ab);
      b  = 32'h0;
      n0 = 0;
      ab = 1'b0;
      go = 1'b1;
      tick();
      go = 1'b0;
      check("tip_rise", 32'(tip), 32'h1);
      for (int i = 0; i < 40; i++) begin
         if (i == abort_at) begin
            check("pre_abort_tip", 32'(tip), 32'h1);
            check("pre_abort_mosi", 32'(mosi), 32'h1);
            wb_reset = 1'b0;
            tick();
            wb_reset = 1'b1;
            ab = 1'b1;
            return;
         end
         if (i == inject_at) begin
            latch    = 4'b0001;
            byte_sel = 4'hF;
            p_in     = 32'hFFFF_FFFF;
            go       = 1'b1;
            tick();
            latch    = 4'h0;
            byte_sel = 4'h0;
            p_in     = 32'h0;
            go       = 1'b0;
            check("tip_held", 32'(tip), 32'h1);
         end
         tick();
         tick();
         strobe0();
         n0++;
         if (!tip) return;
         b = {b[30:0], mosi};
         tick();
         tick();
         strobe1();
      end
      check("tip_timeout", 32'(tip), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wb_reset   = 1'b0;
      go         = 1'b0;
      len        = 5'd0;
      lsb        = 1'b0;
      rx_negedge = 1'b1;
      tx_negedge = 1'b0;
      latch      = 4'h0;
      byte_sel   = 4'h0;
      p_in       = 32'h0;
      sclk       = 1'b0;
      cpol_0     = 1'b0;
      cpol_1     = 1'b0;
      loop_en    = 1'b0;
      miso_drv   = 1'b0;

      // Reset
      tick();
      check("rst_p_out", p_out, 32'h0);
      check("rst_tip", 32'(tip), 32'h0);
      check("rst_last", 32'(last), 32'h1);
      check("rst_mosi", 32'(mosi), 32'h0);
      wb_reset = 1'b1;

      // Byte-selective load
      load(4'b0001, 4'b0001, 32'h0000_aa55);
      check("load_byte0", p_out, 32'h0000_0055);
      load(4'b0001, 4'b0010, 32'h0000_aa55);
      check("load_byte1", p_out, 32'h0000_aa55);
      load(4'b0010, 4'hF, 32'hFFFF_FFFF);
      check("load_word1_ignored", p_out, 32'h0000_aa55);
      check("idle_last", 32'(last), 32'h0);

      // LSB first, 4 bits, miso held high
      len        = 5'd4;
      lsb        = 1'b1;
      rx_negedge = 1'b1;
      tx_negedge = 1'b0;
      loop_en    = 1'b0;
      miso_drv   = 1'b1;
      load(4'b0001, 4'hF, 32'h0000_0055);
      tick();
      check("lsb_idle_mosi", 32'(mosi), 32'h1);
      run_xfer(-1, -1, bits, strobes, aborted);
      check("lsb_bits", 32'(bits[3:0]), 32'hA);
      check("lsb_strobes", 32'(strobes), 32'd5);
      check("lsb_p_out", p_out, 32'h0000_005F);
      check("lsb_tip_end", 32'(tip), 32'h0);

      // MSB first, 8 bits, loop-back
      len     = 5'd8;
      lsb     = 1'b0;
      loop_en = 1'b1;
      load(4'b0001, 4'hF, 32'h0000_00A5);
      run_xfer(-1, -1, bits, strobes, aborted);
      check("msb_bits", 32'(bits[7:0]), 32'hA5);
      check("msb_strobes", 32'(strobes), 32'd9);
      check("msb_p_out", p_out, 32'h0000_00A5);

      // Full length, loop-back
      len = 5'd0;
      load(4'b0001, 4'hF, 32'hDEAD_BEEF);
      run_xfer(-1, -1, bits, strobes, aborted);
      check("full_bits", bits, 32'hDEAD_BEEF);
      check("full_strobes", 32'(strobes), 32'd33);
      check("full_p_out", p_out, 32'hDEAD_BEEF);

      // Writes and go during a transfer are ignored; miso held low
      len      = 5'd8;
      lsb      = 1'b0;
      loop_en  = 1'b0;
      miso_drv = 1'b0;
      load(4'b0001, 4'hF, 32'h1234_5678);
      run_xfer(3, -1, bits, strobes, aborted);
      check("prot_bits", 32'(bits[7:0]), 32'h78);
      check("prot_strobes", 32'(strobes), 32'd9);
      check("prot_p_out", p_out, 32'h1234_5600);

      // Reset mid-transfer
      load(4'b0001, 4'hF, 32'hFFFF_FFFF);
      run_xfer(-1, 2, bits, strobes, aborted);
      check("abort_taken", 32'(aborted), 32'h1);
      check("abort_p_out", p_out, 32'h0);
      check("abort_tip", 32'(tip), 32'h0);
      check("abort_last", 32'(last), 32'h1);
      check("abort_mosi", 32'(mosi), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_shift.md
# spi_shift

Parallel-load / serial-shift data engine of the SPI master. It holds one transfer character, shifts it out on `mosi` and samples `miso` into the same register. Bit clocking comes from one-cycle edge strobes produced by the SPI clock generator. It sits between the Wishbone register file (parallel load, `p_out` readback, `go`) and the SPI pins.

## Interface
Parameters:
- `SPI_MAX_CHAR`, 32: shift register width, the maximum character length in bits.
- `SPI_CHAR_LEN_BITS`, 5: width of `len`, equal to log2(`SPI_MAX_CHAR`).

Ports:
- `wb_clk` in 1: the single clock. All state updates on its rising edge.
- `wb_reset` in 1: synchronous, active-low reset.
- `go` in 1: start-transfer request, level sampled.
- `len` in `SPI_CHAR_LEN_BITS`: character length. 0 means `SPI_MAX_CHAR` bits.
- `lsb` in 1: 1 = LSB first, 0 = MSB first.
- `rx_negedge` in 1: 1 = sample `miso` on the falling-edge strobe, 0 = on the rising-edge strobe.
- `tx_negedge` in 1: 1 = drive `mosi` on the falling-edge strobe, 0 = on the rising-edge strobe.
- `latch` in 4: word write strobes. `latch[i]` targets data bits [32i+31:32i]. Words beyond `SPI_MAX_CHAR` are ignored.
- `byte_sel` in 4: byte enables within the latched word.
- `p_in` in 32: parallel write data.
- `sclk` in 1: current serial clock level.
- `cpol_0` in 1: one-cycle strobe marking the sclk rising (leading) edge.
- `cpol_1` in 1: one-cycle strobe marking the sclk falling (trailing) edge.
- `miso` in 1: serial input.
- `p_out` out `SPI_MAX_CHAR`: data register contents.
- `mosi` out 1: serial output, registered.
- `tip` out 1: transfer in progress.
- `last` out 1: bit counter is zero.

## Operation
Registers are `data[SPI_MAX_CHAR-1:0]`, `cnt[SPI_CHAR_LEN_BITS:0]`, `tip` and `mosi`. `p_out` = `data`.

Define `L` = (`len`==0) ? `SPI_MAX_CHAR` : `len`.

- **Idle (`tip`=0)**
  - `cnt` <= `L` every cycle.
  - Parallel load: for each `latch[i]`=1 and `byte_sel[j]`=1, `data[32i+8j+7:32i+8j]` <= `p_in[8j+7:8j]`.
  - `mosi` <= `data[tx_pos]` every cycle.
- **Start**
  - `go`=1 with `tip`=0 sets `tip`=1 on the next edge.
  - `go` while `tip`=1 has no effect.
  - Writes (`latch`) while `tip`=1 are ignored.
- **Counting (`tip`=1)**
  - `cnt` decrements by 1 on each `cpol_0` strobe; it holds otherwise.
  - `last` = (`cnt`==0), combinational.
- **Transmit**
  - `tx_clk` = (`tx_negedge` ? `cpol_1` : `cpol_0`) & !`last`.
  - On `tx_clk`, `mosi` <= `data[tx_pos]`.
  - `tx_pos` = `lsb` ? (`L` − `cnt`) : (`cnt` − 1).
- **Receive**
  - `rx_clk` = (`rx_negedge` ? `cpol_1` : `cpol_0`) & (!`last` | `sclk`).
  - On `rx_clk` with `tip`=1, `data[rx_pos]` <= `miso`.
  - If `lsb`=1: `rx_pos` = `L` − (`rx_negedge` ? `cnt`+1 : `cnt`).
  - If `lsb`=0: `rx_pos` = `rx_negedge` ? `cnt` : `cnt`−1.
  - The received bit replaces the transmitted bit in place. Bits above `L`−1 are untouched.
- **End**: `tip` clears on the edge where `tip`=1, `last`=1 and `cpol_0`=1.
- Bit-position arithmetic is `SPI_CHAR_LEN_BITS`+1 wide, truncated to the index width.

## Timing
- Reset values (`wb_reset`=0 at a clock edge): `data`=0, `cnt`=0, `tip`=0, `mosi`=0. Consequently `last`=1 and `p_out`=0.
- Reset has priority over `go`, `latch` and the strobes. Reset mid-transfer aborts immediately, and the partially received data is lost.
- `tip` rises 1 cycle after `go` is sampled. The first shift occurs on the next qualifying strobe.
- A character of `L` bits takes `L` `cpol_0` strobes to count down. `tip` falls on the following `cpol_0` strobe.
- If `cpol_0` and `cpol_1` are asserted in the same cycle, both actions are performed. The clock generator never does this.
- `len` and `lsb` must be stable while `tip`=1. Changing them mid-transfer gives undefined bit ordering, but there is no lock-up: the transfer still terminates when `cnt` reaches 0.

## Test plan
- **Reset:** drive `wb_reset`=0 for 1 cycle. Require `p_out`=0, `tip`=0, `last`=1 and `mosi`=0.
- **Byte-selective load:** `latch`=0001, `byte_sel`=0001, `p_in`=32'h0000aa55, idle. Require `p_out`=32'h00000055. Repeat with `byte_sel`=0010; require `p_out`=32'h0000aa55.
- **LSB-first, 4 bits:** `len`=4, `lsb`=1, `rx_negedge`=1, `tx_negedge`=0, data=0x55, divider strobes every 3 cycles, pulse `go`.
  - `mosi` must present bits 1,0,1,0.
  - Holding `miso`=1 throughout gives `p_out`[3:0]=4'hF and upper bits unchanged (0x5F).
  - `tip` falls after the 5th `cpol_0` strobe.
- **MSB-first, 8 bits:** `len`=8, `lsb`=0, data=0xA5, `miso` looped to `mosi`.
  - `mosi` sequence is 1,0,1,0,0,1,0,1.
  - After completion `p_out`[7:0]=0xA5.
- **Full length:** `len`=0 with 32'hDEADBEEF. Require 32 shifted bits, `tip` high for 33 `cpol_0` strobes, and the loop-back result equal to 32'hDEADBEEF.
- **Protection during transfer:** assert `latch` and `go` while `tip`=1. Require no change to the transfer, and `p_out` reflects only received bits. Assert reset mid-transfer; require all outputs to return to their reset values on the next edge.
